// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit sequencer and its byte FIFO.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } spi_seq_state_t;

  localparam int   SPI_BITS_PER_BYTE = 8;
  localparam logic SPI_CS_ACTIVE     = 1'b0;

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous byte FIFO; pointers wrap modulo DEPTH and level separates full from empty.
module spi_byte_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SPI_BITS_PER_BYTE-1:0] push_data,
  input  logic                         push,
  input  logic                         pop,
  output logic [SPI_BITS_PER_BYTE-1:0] pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int AW = $clog2(DEPTH);

  logic [SPI_BITS_PER_BYTE-1:0] mem [DEPTH];
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_ptr;
  logic                         do_push;
  logic                         do_pop;

  // full comes from the registered level, so a pop never makes room for a same-cycle push
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_tx_sequencer.sv
// Feeds queued bytes to an SPI master, framing them with an active-low chip select.
// Build option SPI_TX_SEQ_GAP_EN: frame every byte separately with GAP_CYCLES idle cycles.
module spi_tx_sequencer
  import spi_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [7:0]             p_data_out,
  output logic                   cs,
  output logic                   busy,
  output logic                   byte_done,
  output logic [$clog2(DEPTH):0] level
);

  spi_seq_state_t state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           pop;
  logic [7:0]     fifo_data;
  logic           full;
  logic           empty;
  logic           last_bit;

`ifdef SPI_TX_SEQ_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_q, gap_d;
`else
  logic unused_gap_cfg;
  assign unused_gap_cfg = |GAP_CYCLES;
`endif

  spi_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_data (wr_data),
    .push      (wr_valid),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign wr_ready  = !full;
  assign last_bit  = (bit_cnt_q == 3'(SPI_BITS_PER_BYTE - 1));
  assign cs        = (state_q == SHIFT) ? SPI_CS_ACTIVE : !SPI_CS_ACTIVE;
  assign byte_done = (state_q == SHIFT) && last_bit;
  assign busy      = (state_q != IDLE) || !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      p_data_out <= 8'h00;
`ifdef SPI_TX_SEQ_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      if (pop) p_data_out <= fifo_data;
`ifdef SPI_TX_SEQ_GAP_EN
      gap_q     <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
`ifdef SPI_TX_SEQ_GAP_EN
    gap_d     = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (last_bit) begin
`ifdef SPI_TX_SEQ_GAP_EN
          state_d = GAP;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
`else
          // next byte follows with no gap so cs stays low across the burst
          if (!empty) begin
            pop       = 1'b1;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef SPI_TX_SEQ_GAP_EN
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Randomized bench for spi_tx_sequencer against a schedule model of byte start times.
`timescale 1ns/1ps
module tb_spi_tx_sequencer;

  localparam int DEPTH      = 4;
  localparam int GAP_CYCLES = 2;
  localparam int LW         = $clog2(DEPTH) + 1;
`ifdef SPI_TX_SEQ_GAP_EN
  localparam int FRAME_GAP = GAP_CYCLES + 1;
  localparam int GAP_HOLD  = GAP_CYCLES;
`else
  localparam int FRAME_GAP = 0;
  localparam int GAP_HOLD  = 0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [7:0]    p_data_out;
  logic          cs;
  logic          busy;
  logic          byte_done;
  logic [LW-1:0] level;

  spi_tx_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .p_data_out (p_data_out),
    .cs         (cs),
    .busy       (busy),
    .byte_done  (byte_done),
    .level      (level)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model: acceptance edge, scheduled first shift cycle and value of every byte since reset
  int         acc_q[$];
  int         st_q[$];
  logic [7:0] dat_q[$];
  int         last_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    acc_q.delete();
    st_q.delete();
    dat_q.delete();
    last_s = -1000;
    cyc    = 0;
  endtask

  function automatic void model_at(input int c, output logic o_cs, output logic [7:0] o_pd,
                                   output logic o_done, output logic o_busy, output int o_lvl);
    int n_acc = 0;
    int n_st  = 0;
    foreach (acc_q[i]) if (acc_q[i] <= c) n_acc++;
    foreach (st_q[i])  if (st_q[i]  <= c) n_st++;
    o_lvl  = n_acc - n_st;
    o_cs   = 1'b1;
    o_pd   = 8'h00;
    o_done = 1'b0;
    o_busy = (o_lvl > 0);
    foreach (st_q[i]) begin
      if (st_q[i] <= c) begin
        o_pd = dat_q[i];
        if (c <= st_q[i] + 7)            o_cs   = 1'b0;
        if (c == st_q[i] + 7)            o_done = 1'b1;
        if (c <= st_q[i] + 7 + GAP_HOLD) o_busy = 1'b1;
      end
    end
  endfunction

  // check the current cycle, then drive the inputs seen by the next rising edge
  task automatic step(input logic v, input logic [7:0] d, output logic took);
    logic       e_cs, e_done, e_busy, e_ready;
    logic [7:0] e_pd;
    int         e_lvl, a, s;
    model_at(cyc, e_cs, e_pd, e_done, e_busy, e_lvl);
    e_ready = (e_lvl < DEPTH);
    chk("cs",         32'(cs),         32'(e_cs));
    chk("p_data_out", 32'(p_data_out), 32'(e_pd));
    chk("byte_done",  32'(byte_done),  32'(e_done));
    chk("busy",       32'(busy),       32'(e_busy));
    chk("level",      32'(level),      32'(e_lvl));
    chk("wr_ready",   32'(wr_ready),   32'(e_ready));
    wr_valid = v;
    wr_data  = d;
    took     = v && e_ready;
    if (took) begin
      a = cyc + 1;
      s = (a + 1 > last_s + 8 + FRAME_GAP) ? a + 1 : last_s + 8 + FRAME_GAP;
      acc_q.push_back(a);
      st_q.push_back(s);
      dat_q.push_back(d);
      last_s = s;
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle(input int n);
    logic t;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, t);
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_cs"},       32'(cs),         32'd1);
    chk({pfx, "_pdata"},    32'(p_data_out), 32'h00);
    chk({pfx, "_done"},     32'(byte_done),  32'd0);
    chk({pfx, "_busy"},     32'(busy),       32'd0);
    chk({pfx, "_level"},    32'(level),      32'd0);
    chk({pfx, "_wr_ready"}, 32'(wr_ready),   32'd1);
  endtask

  // reset lands between clock edges; outputs must clear before the next edge
  task automatic reset_mid();
    #2 reset = 1'b1;
    #1 check_reset_values("rst_mid");
    wr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  logic t;
  int   k, guard, p;

  initial begin
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    model_clear();
    #1 reset = 1'b1;
    #1 check_reset_values("rst_init");
    @(negedge clock);
    reset = 1'b0;
    model_clear();

    idle(3);

    step(1'b1, 8'hE9, t);
    chk("single_accept", 32'(t), 32'd1);
    idle(25);

    step(1'b1, 8'hA5, t);
    step(1'b1, 8'h3C, t);
    step(1'b1, 8'hFF, t);
    idle(45);

    k = 1;
    guard = 0;
    while (k <= 6 && guard < 200) begin
      step(1'b1, 8'(k), t);
      if (t) k++;
      guard++;
    end
    chk("fill_all_accepted", 32'(k), 32'd7);
    idle(80);

    for (int seg = 0; seg < 8; seg++) begin
      p = $urandom_range(10, 100);
      for (int i = 0; i < 90; i++)
        step(($urandom_range(0, 99) < p), 8'($urandom_range(0, 255)), t);
    end
    idle(80);

    step(1'b1, 8'h5A, t);
    step(1'b1, 8'hC3, t);
    step(1'b1, 8'h81, t);
    idle(12);
    reset_mid();
    idle(30);

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)), t);
    idle(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
